xil_mem_dp_arb: RTL and testbench

- Round-robin arbiter that shares one port of a 1024x16 dual-port block RAM (byte write enables, 1-cycle registered-address read) among NUM_REQ requesters.
- Drives the memory port combinationally from the winning request and returns read data one cycle later, tagged with a one-hot valid.
- Sits between several engines (DMA, CPU mailbox) and a single RAM port; the other RAM port remains private to its owner.

---
 rtl/xil_mem_dp_arb_pkg.sv | 21 ++
 rtl/xil_rr_pick.sv | 32 +++
 rtl/xil_mem_dp_arb.sv | 133 +++++++++++++
 tb/tb_xil_mem_dp_arb.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xil_mem_dp_arb_pkg.sv
// Shared memory-port definitions for the xil_mem_dp_arb block-RAM arbiter.
// Holds the RAM geometry, the read-encoding of the byte enables and the request record.
package xil_mem_dp_arb_pkg;

    localparam int MEM_ADR_W  = 10;
    localparam int MEM_DATA_W = 16;
    localparam int MEM_WEN_W  = 2;

    localparam logic [MEM_WEN_W-1:0] WEN_READ = 2'b00;

    typedef struct packed {
        logic [MEM_WEN_W-1:0]  wen;
        logic [MEM_ADR_W-1:0]  adr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic is_read(input logic [MEM_WEN_W-1:0] wen);
        return wen == WEN_READ;
    endfunction

endpackage

// File: rtl/xil_rr_pick.sv
// Rotating priority encoder: first asserted request at or after i_start (mod NUM_REQ)
// wins; returns the one-hot grant, its index and an any-grant flag.
module xil_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int RR_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [RR_W-1:0]    i_start,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [RR_W-1:0]    o_idx,
    output logic               o_any
);

    logic [RR_W-1:0] k;

    // NOTE: every output gets a default before the search loop, so no path leaves a latch.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = RR_W'((int'(i_start) + i) % NUM_REQ);
            if (!o_any && i_req[k]) begin
                o_any    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = k;
            end
        end
    end

endmodule

// File: rtl/xil_mem_dp_arb.sv
// Round-robin arbiter sharing one 1024x16 block-RAM port among NUM_REQ requesters.
// Define XIL_MEM_ARB_LOCK_EN to let a requester hold ownership across accesses.
module xil_mem_dp_arb
    import xil_mem_dp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RR_W    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [MEM_WEN_W*NUM_REQ-1:0]    i_req_wen,
    input  logic [MEM_ADR_W*NUM_REQ-1:0]    i_req_adr,
    input  logic [MEM_DATA_W*NUM_REQ-1:0]   i_req_wdata,
    input  logic [NUM_REQ-1:0]              i_req_lock,
    output logic [NUM_REQ-1:0]              o_req_ack,
    output logic [NUM_REQ-1:0]              o_rd_valid,
    output logic [MEM_DATA_W-1:0]           o_rdata,
    output logic                            o_mem_en,
    output logic [MEM_WEN_W-1:0]            o_mem_wen,
    output logic [MEM_ADR_W-1:0]            o_mem_adr,
    output logic [MEM_DATA_W-1:0]           o_mem_wdata,
    input  logic [MEM_DATA_W-1:0]           i_mem_rdata
);

    logic [RR_W-1:0]    rr_q, rr_d;
    logic               rd_vld_q, rd_vld_d;
    logic [RR_W-1:0]    rd_idx_q, rd_idx_d;
    logic [NUM_REQ-1:0] req_elig;
    logic [NUM_REQ-1:0] gnt;
    logic [RR_W-1:0]    gnt_idx;
    logic               gnt_any;
    mem_req_t           sel;

`ifdef XIL_MEM_ARB_LOCK_EN
    logic               own_vld_q, own_vld_d;
    logic [RR_W-1:0]    own_idx_q, own_idx_d;
`else
    logic               unused_lock;
    assign unused_lock = ^i_req_lock;
`endif

    // Nothing is granted during reset; an active owner masks everyone else.
    always_comb begin
        req_elig = rst ? '0 : i_req_valid;
`ifdef XIL_MEM_ARB_LOCK_EN
        if (own_vld_q) begin
            req_elig = req_elig & (NUM_REQ'(1) << own_idx_q);
        end
`endif
    end

    xil_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .RR_W    (RR_W)
    ) u_pick (
        .i_req   (req_elig),
        .i_start (rr_q),
        .o_gnt   (gnt),
        .o_idx   (gnt_idx),
        .o_any   (gnt_any)
    );

    always_comb begin
        sel.wen   = i_req_wen[gnt_idx*MEM_WEN_W +: MEM_WEN_W];
        sel.adr   = i_req_adr[gnt_idx*MEM_ADR_W +: MEM_ADR_W];
        sel.wdata = i_req_wdata[gnt_idx*MEM_DATA_W +: MEM_DATA_W];
    end

    assign o_req_ack   = gnt;
    assign o_mem_en    = gnt_any;
    assign o_mem_wen   = gnt_any ? sel.wen   : '0;
    assign o_mem_adr   = gnt_any ? sel.adr   : '0;
    assign o_mem_wdata = gnt_any ? sel.wdata : '0;
    assign o_rdata     = i_mem_rdata;

    always_comb begin
        rr_d     = rr_q;
        rd_vld_d = gnt_any && is_read(sel.wen);
        rd_idx_d = gnt_idx;
`ifdef XIL_MEM_ARB_LOCK_EN
        own_vld_d = own_vld_q;
        own_idx_d = own_idx_q;
        if (gnt_any) begin
            own_vld_d = i_req_lock[gnt_idx];
            own_idx_d = gnt_idx;
        end
        // The pointer stays put while ownership persists and moves on the releasing grant.
        if (gnt_any && !own_vld_d) begin
            rr_d = (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
`else
        if (gnt_any) begin
            rr_d = (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
`endif
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= '0;
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
`ifdef XIL_MEM_ARB_LOCK_EN
            own_vld_q <= 1'b0;
            own_idx_q <= '0;
`endif
        end else begin
            rr_q      <= rr_d;
            rd_vld_q  <= rd_vld_d;
            rd_idx_q  <= rd_idx_d;
`ifdef XIL_MEM_ARB_LOCK_EN
            own_vld_q <= own_vld_d;
            own_idx_q <= own_idx_d;
`endif
        end
    end

    always_comb begin
        o_rd_valid = '0;
        if (rd_vld_q) begin
            o_rd_valid[rd_idx_q] = 1'b1;
        end
    end

    // A pending request must stay valid until it is acknowledged.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
        a_hold_valid: assert property (@(posedge clk) disable iff (rst)
            (i_req_valid[i] && !o_req_ack[i]) |=> i_req_valid[i]);
    end

endmodule

// File: tb/tb_xil_mem_dp_arb.sv
// Scoreboard bench for xil_mem_dp_arb: directed scenarios plus randomized traffic against
// a behavioural arbiter/memory model; honours XIL_MEM_ARB_LOCK_EN when defined.
module tb_xil_mem_dp_arb;
    import xil_mem_dp_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 2;

    logic               clk;
    logic               rst;
    logic [N-1:0]       i_req_valid;
    logic [2*N-1:0]     i_req_wen;
    logic [10*N-1:0]    i_req_adr;
    logic [16*N-1:0]    i_req_wdata;
    logic [N-1:0]       i_req_lock;
    logic [N-1:0]       o_req_ack;
    logic [N-1:0]       o_rd_valid;
    logic [15:0]        o_rdata;
    logic               o_mem_en;
    logic [1:0]         o_mem_wen;
    logic [9:0]         o_mem_adr;
    logic [15:0]        o_mem_wdata;
    logic [15:0]        i_mem_rdata;

    xil_mem_dp_arb #(.NUM_REQ(N), .RR_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_wen   (i_req_wen),
        .i_req_adr   (i_req_adr),
        .i_req_wdata (i_req_wdata),
        .i_req_lock  (i_req_lock),
        .o_req_ack   (o_req_ack),
        .o_rd_valid  (o_rd_valid),
        .o_rdata     (o_rdata),
        .o_mem_en    (o_mem_en),
        .o_mem_wen   (o_mem_wen),
        .o_mem_adr   (o_mem_adr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503) ^ 16'hC3A5;
    endfunction

    // Block-RAM stand-in: byte-enabled write-first storage with a registered read address.
    bit [15:0] ram    [1024];
    bit        ram_wr [1024];
    bit [9:0]  ram_adr_q;

    function automatic logic [15:0] env_rd(input int a);
        return ram_wr[a] ? ram[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_wen != 2'b00) begin
                ram[o_mem_adr] <= (env_rd(int'(o_mem_adr)) & ~{{8{o_mem_wen[1]}}, {8{o_mem_wen[0]}}})
                                | (o_mem_wdata & {{8{o_mem_wen[1]}}, {8{o_mem_wen[0]}}});
                ram_wr[o_mem_adr] <= 1'b1;
            end
            ram_adr_q <= o_mem_adr;
        end
    end

    always_comb i_mem_rdata = env_rd(int'(ram_adr_q));

    int n_checks;
    int n_errs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural reference: round-robin order, word memory, expected read returns.
    typedef struct {
        bit          idle;
        logic [1:0]  wen;
        logic [9:0]  adr;
        logic [15:0] wdata;
        bit          lock;
    } tb_req_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [15:0] data;
    } sb_t;

    logic [15:0] m_mem [int];
    int          m_rr;
    bit          m_own_vld;
    int          m_own;
    bit          m_gnt_last [N];
    sb_t         sb [$];
    int          ack_log [$];
    int          exp_log [$];
    logic [15:0] last_rdata;

    tb_req_t rq [N][$];
    bit      pres      [N];
    bit      pres_idle [N];
    bit      rand_mode;

    function automatic logic [15:0] model_rd(input int a);
        return m_mem.exists(a) ? m_mem[a] : init_word(a);
    endfunction

    task automatic model_wr(input int a, input logic [1:0] wen, input logic [15:0] wd);
        logic [15:0] w;
        w = model_rd(a);
        for (int b = 0; b < 2; b++) begin
            if (wen[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        end
        m_mem[a] = w;
    endtask

    task automatic arb_check();
        int          g;
        bit          seen;
        logic [N-1:0] elig;
        logic [N-1:0] exp_ack;
        logic [1:0]  wen;
        logic [9:0]  adr;
        logic [15:0] wd;
        g    = -1;
        seen = 1'b0;
        elig = rst ? '0 : i_req_valid;
`ifdef XIL_MEM_ARB_LOCK_EN
        if (m_own_vld) elig = elig & (N'(1) << m_own);
`endif
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (g < 0 && elig[j]) g = j;
        end
        exp_ack = '0;
        if (g >= 0) exp_ack[g] = 1'b1;
        check("ack", o_req_ack, exp_ack);
        check("mem_en", o_mem_en, g >= 0);
        for (int i = 0; i < N; i++) begin
            m_gnt_last[i] = (i == g);
            if (o_req_ack[i] && !seen) begin
                ack_log.push_back(i);
                seen = 1'b1;
            end
        end
        if (rst) begin
            m_rr      = 0;
            m_own_vld = 1'b0;
        end else if (g >= 0) begin
            wen = i_req_wen[g*2 +: 2];
            adr = i_req_adr[g*10 +: 10];
            wd  = i_req_wdata[g*16 +: 16];
            check("mem_port", {o_mem_wen, o_mem_adr, o_mem_wdata}, {wen, adr, wd});
            if (wen == 2'b00) sb.push_back('{cyc + 1, g, model_rd(int'(adr))});
            else model_wr(int'(adr), wen, wd);
`ifdef XIL_MEM_ARB_LOCK_EN
            m_own_vld = i_req_lock[g];
            m_own     = g;
            if (!m_own_vld) m_rr = (g + 1) % N;
`else
            m_rr = (g + 1) % N;
`endif
        end
    endtask

    // Monitor: whenever a return is due or o_rd_valid is raised, pop and compare.
    always @(negedge clk) begin
        sb_t         e;
        logic [N-1:0] exp_v;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            exp_v = '0;
            exp_v[e.idx] = 1'b1;
            check("rd_valid", o_rd_valid, exp_v);
            check("rdata", o_rdata, e.data);
            last_rdata = o_rdata;
        end else if (o_rd_valid != '0) begin
            check("rd_valid_spurious", o_rd_valid, '0);
        end
    end

    function automatic tb_req_t mk(input bit idle, input logic [1:0] wen, input int adr,
                                   input logic [15:0] wd, input bit lock);
        tb_req_t r;
        r.idle  = idle;
        r.wen   = wen;
        r.adr   = 10'(adr);
        r.wdata = wd;
        r.lock  = lock;
        return r;
    endfunction

    task automatic rd(input int i, input int a, input bit lk);
        rq[i].push_back(mk(1'b0, 2'b00, a, 16'h0, lk));
    endtask

    task automatic wr(input int i, input int a, input logic [15:0] d, input logic [1:0] wen);
        rq[i].push_back(mk(1'b0, wen, a, d, 1'b0));
    endtask

    task automatic idle(input int i);
        rq[i].push_back(mk(1'b1, 2'b00, 0, 16'h0, 1'b0));
    endtask

    function automatic tb_req_t rand_req();
        logic [1:0] wen;
        int         a;
        wen = ($urandom_range(1) == 0) ? 2'b00 : 2'($urandom_range(3, 1));
        a   = ($urandom_range(9) < 7) ? int'($urandom_range(15)) : int'($urandom_range(1023));
        return mk($urandom_range(99) < 15, wen, a, 16'($urandom), $urandom_range(99) < 20);
    endfunction

    task automatic advance_drivers();
        for (int i = 0; i < N; i++) begin
            if (pres[i] && (pres_idle[i] || m_gnt_last[i])) begin
                rq[i].delete(0);
                pres[i] = 1'b0;
            end
            if (rand_mode && !pres[i] && rq[i].size() == 0 && $urandom_range(99) < 60)
                rq[i].push_back(rand_req());
            if (!pres[i] && rq[i].size() > 0) begin
                pres[i]      = 1'b1;
                pres_idle[i] = rq[i][0].idle;
                i_req_wen[i*2 +: 2]     = rq[i][0].wen;
                i_req_adr[i*10 +: 10]   = rq[i][0].adr;
                i_req_wdata[i*16 +: 16] = rq[i][0].wdata;
                i_req_lock[i]           = rq[i][0].lock;
            end
            i_req_valid[i] = pres[i] && !pres_idle[i];
            m_gnt_last[i]  = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        arb_check();
        @(posedge clk);
        #1;
        advance_drivers();
    endtask

    function automatic bit busy();
        bit b;
        b = 1'b0;
        for (int i = 0; i < N; i++) b |= pres[i] || (rq[i].size() > 0);
        return b;
    endfunction

    task automatic drain(input string name, input int max_cyc);
        int c;
        c = 0;
        advance_drivers();
        while (busy() && c < max_cyc) begin
            step();
            c++;
        end
        check({name, "_done"}, busy(), 1'b0);
        step();
        step();
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, ack_log.size(), exp_log.size());
        for (int k = 0; k < exp_log.size(); k++)
            check(name, (k < ack_log.size()) ? ack_log[k] : -1, exp_log[k]);
        ack_log.delete();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        rand_mode   = 1'b0;
        i_req_valid = '0;
        i_req_wen   = '0;
        i_req_adr   = '0;
        i_req_wdata = '0;
        i_req_lock  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", o_req_ack, '0);
        check("reset_mem_en", o_mem_en, 1'b0);
        check("reset_rd_valid", o_rd_valid, '0);
        m_rr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four continuously reading distinct addresses.
        ack_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) rd(i, 100 + 8*r + i, 1'b0);
        drain("rr_all", 50);
        exp_log = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log("rr_all_order");

        // Full write to the top address, read back by another requester.
        wr(1, 'h3FF, 16'h3A5C, 2'b11);
        idle(2);
        rd(2, 'h3FF, 1'b0);
        drain("raw", 50);
        check("raw_rdata", last_rdata, 16'h3A5C);

        // Low-byte-only write over an existing word.
        wr(0, 'h010, 16'h1234, 2'b11);
        wr(0, 'h010, 16'h00FF, 2'b01);
        rd(0, 'h010, 1'b0);
        drain("partial", 50);
        check("partial_rdata", last_rdata, 16'h12FF);
        ack_log.delete();

        // Req3 alone from pointer 0, idle gap, then everyone.
        reset_pulse();
        rd(3, 'h20, 1'b0);
        repeat (3) idle(3);
        rd(3, 'h21, 1'b0);
        for (int i = 0; i < 3; i++) begin
            repeat (4) idle(i);
            rd(i, 'h30 + i, 1'b0);
        end
        drain("wrap", 50);
        exp_log = '{3, 0, 1, 2, 3};
        check_log("wrap_order");

        // Reset while a read is pending: no grant, no return, lowest index first after.
        rd(0, 'h40, 1'b0);
        rd(2, 'h41, 1'b0);
        rst = 1'b1;
        advance_drivers();
        @(negedge clk);
        arb_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rd_valid", o_rd_valid, '0);
        arb_check();
        @(posedge clk);
        #1;
        advance_drivers();
        drain("rst_mid", 50);
        exp_log = '{0, 2};
        check_log("rst_mid_order");

        // Req2 holds the port with lock while reqs 0 and 1 wait.
        rd(2, 'h50, 1'b1);
        rd(2, 'h51, 1'b1);
        rd(2, 'h52, 1'b0);
        idle(0);
        rd(0, 'h53, 1'b0);
        idle(1);
        rd(1, 'h54, 1'b0);
        drain("lock", 50);
`ifdef XIL_MEM_ARB_LOCK_EN
        exp_log = '{2, 2, 2, 0, 1};
`else
        exp_log = '{2, 0, 1, 2, 2};
`endif
        check_log("lock_order");

        // Randomized traffic with occasional reset pulses.
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(99) == 0);
            step();
        end
        rand_mode = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < N; i++) rd(i, i, 1'b0);
        drain("random", 400);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
